// File: rtl/tx_uart_pkg.sv
// tx_uart_pkg -- UART definitions shared by the transmitter and the receiver.
// Holds the common FSM state encoding and a counter-width helper so that both
// directions of the link agree on state numbering and counter sizing.
package tx_uart_pkg;

  // FSM states; PARITY is only reachable when the parity option is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_t;

  localparam int UART_DBIT_DEFAULT    = 8;
  localparam int UART_SB_TICK_DEFAULT = 16;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_uart.sv
// tx_uart -- UART transmitter (start bit, DBIT data bits LSB first, one stop bit).
// Bit timing comes from an external oversampling tick (i_s_tick) shared with
// the receiver; one bit period is SB_TICK ticks.
// Optional feature: define TX_UART_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module tx_uart
  import tx_uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT_DEFAULT,
  parameter int SB_TICK = UART_SB_TICK_DEFAULT
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic            i_s_tick,
  input  logic [DBIT-1:0] i_data,
  output logic            o_tx,
  output logic            o_tx_done_tick,
  output logic            o_busy
);

  localparam int TW = cnt_width(SB_TICK);
  localparam int DW = cnt_width(DBIT);

  localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
  localparam logic [DW-1:0] BIT_LAST  = DW'(DBIT - 1);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [DW-1:0] BIT_ZERO  = {DW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] BIT_ONE   = {{(DW-1){1'b0}}, 1'b1};

  uart_state_t     state_r,    state_s;
  logic [TW-1:0]   tick_cnt_r, tick_cnt_s;
  logic [DW-1:0]   data_cnt_r, data_cnt_s;
  logic [DBIT-1:0] shift_r,    shift_s;
  logic            tx_r,       tx_s;
  logic            done_r,     done_s;
  logic            busy_r,     busy_s;
  logic            bit_end_s;

`ifdef TX_UART_PARITY_EN
  logic            parity_r,   parity_s;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DBIT-1:0] d);
    return ^d;
  endfunction
`endif

  // State and datapath registers; reset aborts any frame and idles the line high.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= IDLE;
      tick_cnt_r <= TICK_ZERO;
      data_cnt_r <= BIT_ZERO;
      shift_r    <= {DBIT{1'b0}};
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
`ifdef TX_UART_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      data_cnt_r <= data_cnt_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
`ifdef TX_UART_PARITY_EN
      parity_r   <= parity_s;
`endif
    end
  end

  // Next-state, counter and shift logic, plus next values of the output registers.
  always_comb begin
    state_s    = state_r;
    tick_cnt_s = tick_cnt_r;
    data_cnt_s = data_cnt_r;
    shift_s    = shift_r;
    done_s     = 1'b0;
    tx_s       = 1'b1;
    busy_s     = 1'b0;
`ifdef TX_UART_PARITY_EN
    parity_s   = parity_r;
`endif
    // A bit period ends on the tick that brings the counter to SB_TICK.
    bit_end_s  = i_s_tick && (tick_cnt_r == TICK_LAST);

    case (state_r)
      IDLE: begin
        // Ticks are ignored here; only a start request leaves IDLE.
        if (i_tx_start) begin
          shift_s    = i_data;
          tick_cnt_s = TICK_ZERO;
          state_s    = START;
`ifdef TX_UART_PARITY_EN
          parity_s   = even_parity(i_data);
`endif
        end else begin
          state_s    = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          tick_cnt_s = TICK_ZERO;
          data_cnt_s = BIT_ZERO;
          state_s    = DATA;
        end else if (i_s_tick) begin
          tick_cnt_s = tick_cnt_r + TICK_ONE;
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          tick_cnt_s = TICK_ZERO;
          shift_s    = shift_r >> 1'b1;
          // Hold the bit counter on the last bit so it never wraps.
          if (data_cnt_r == BIT_LAST) begin
            data_cnt_s = data_cnt_r;
`ifdef TX_UART_PARITY_EN
            state_s    = PARITY;
`else
            state_s    = STOP;
`endif
          end else begin
            data_cnt_s = data_cnt_r + BIT_ONE;
          end
        end else if (i_s_tick) begin
          tick_cnt_s = tick_cnt_r + TICK_ONE;
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end

`ifdef TX_UART_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          tick_cnt_s = TICK_ZERO;
          state_s    = STOP;
        end else if (i_s_tick) begin
          tick_cnt_s = tick_cnt_r + TICK_ONE;
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
`endif

      STOP: begin
        if (bit_end_s) begin
          tick_cnt_s = TICK_ZERO;
          done_s     = 1'b1;
          state_s    = IDLE;
        end else if (i_s_tick) begin
          tick_cnt_s = tick_cnt_r + TICK_ONE;
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle line.
        state_s    = IDLE;
        tick_cnt_s = TICK_ZERO;
        data_cnt_s = BIT_ZERO;
      end
    endcase

    // Line level follows the state being entered so o_tx is a pure register.
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef TX_UART_PARITY_EN
      PARITY:  tx_s = parity_s;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase

    busy_s = (state_s != IDLE);
  end

  assign o_tx           = tx_r;
  assign o_tx_done_tick = done_r;
  assign o_busy         = busy_r;

endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart -- directed self-checking bench for tx_uart (DBIT=8, SB_TICK=16,
// one tick every 4 clocks, so one bit period is 64 clocks).
module tb_tx_uart;

  localparam int BIT_CLKS = 64;
`ifdef TX_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic       s_tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       tx_done_tick;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int tick_div = 0;

  tx_uart dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_tx_start     (tx_start),
    .i_s_tick       (s_tick),
    .i_data         (data),
    .o_tx           (tx),
    .o_tx_done_tick (tx_done_tick),
    .o_busy         (busy)
  );

  always #5 clock = ~clock;

  // Baud tick: one-clock pulse every 4 clocks, changed on the falling edge.
  always @(negedge clock) begin
    tick_div = (tick_div == 3) ? 0 : tick_div + 1;
    s_tick = (tick_div == 0);
  end

  // Expected line level of frame bit b (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    logic r;
    if (b == 0) r = 1'b0;
    else if (b <= 8) r = d[b-1];
`ifdef TX_UART_PARITY_EN
    else if (b == 9) r = ^d;
`endif
    else r = 1'b1;
    return r;
  endfunction

  // Request a frame in a cycle that carries a tick, so every bit lasts 64 clocks.
  // Returns on the first falling edge after the accepting rising edge.
  task automatic send(input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge clock); #1;
    while (s_tick !== 1'b1 && guard < 8) begin
      @(negedge clock); #1;
      guard++;
    end
    data = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  // Checks every clock of a frame; optionally pokes i_tx_start at sample poke_at.
  task automatic check_frame(input logic [7:0] d, input int first_len, input int poke_at,
                             input bit tail, input string name);
    int idx, len, bad, busy_bad, done_bad;
    idx = 0;
    done_bad = 0;
    for (int b = 0; b < NBITS; b++) begin
      len = (b == 0) ? first_len : BIT_CLKS;
      bad = 0;
      busy_bad = 0;
      for (int j = 0; j < len; j++) begin
        if (idx == poke_at) begin
          tx_start = 1'b1;
          data = 8'hFF;
        end else if (idx == poke_at + 1) begin
          tx_start = 1'b0;
        end
        if (tx !== exp_bit(d, b)) bad++;
        if (busy !== 1'b1) busy_bad++;
        if (tx_done_tick !== 1'b0) done_bad++;
        idx++;
        @(negedge clock);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit%0d: %0d of %0d clocks wrong, required level %b",
                 name, b, bad, len, exp_bit(d, b));
      end
      checks++;
      if (busy_bad != 0) begin
        errors++;
        $display("FAIL %s busy bit%0d: %0d clocks low, required 1", name, b, busy_bad);
      end
    end
    checks++;
    if (done_bad != 0) begin
      errors++;
      $display("FAIL %s early_done: %0d done clocks inside frame, required 0", name, done_bad);
    end
    checks++;
    if (tx_done_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: got %b required 1", name, tx_done_tick);
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_idle: tx=%b busy=%b required tx=1 busy=0", name, tx, busy);
    end
    if (tail) begin
      @(negedge clock);
      checks++;
      if (tx_done_tick !== 1'b0) begin
        errors++;
        $display("FAIL %s done_width: got %b required 0", name, tx_done_tick);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_start = 1'b1;
    data = 8'hA5;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", tx_done_tick); end
    tx_start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_idle_ticks();
    int bad;
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_ticks: %0d clocks not idle, required 0", bad); end
  endtask

  task automatic test_basic();
    send(8'h55);
    check_frame(8'h55, BIT_CLKS, -1, 1'b1, "frame_55");
  endtask

  task automatic test_ignore_start();
    send(8'h00);
    check_frame(8'h00, BIT_CLKS, BIT_CLKS * 3 + 10, 1'b1, "frame_00_poke");
  endtask

  task automatic test_back_to_back();
    send(8'hA3);
    check_frame(8'hA3, BIT_CLKS, -1, 1'b0, "b2b_first");
    data = 8'h0F;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    checks++;
    if (tx_done_tick !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b required 0", tx_done_tick); end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: tx=%b busy=%b required tx=0 busy=1", tx, busy);
    end
    // Request accepted one clock past a tick, so the first start bit is 63 clocks.
    check_frame(8'h0F, BIT_CLKS - 1, -1, 1'b1, "b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    send(8'h96);
    repeat (BIT_CLKS * 4 + 24) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b required 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      if (tx_done_tick !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_quiet: %0d clocks not idle, required 0", bad); end
    send(8'h3C);
    check_frame(8'h3C, BIT_CLKS, -1, 1'b1, "after_abort_3c");
  endtask

`ifdef TX_UART_PARITY_EN
  task automatic test_parity();
    send(8'h07);
    check_frame(8'h07, BIT_CLKS, -1, 1'b1, "parity_07");
    send(8'h03);
    check_frame(8'h03, BIT_CLKS, -1, 1'b1, "parity_03");
  endtask
`endif

  // Mid-bit sampling receiver model on the serial line.
  task automatic test_loopback(input logic [7:0] d);
    logic [7:0] rx_byte;
    logic start_ok, stop_ok;
    int rx_done, tx_done, b;
    rx_byte = 8'h00;
    start_ok = 1'b0;
    stop_ok = 1'b0;
    rx_done = 0;
    tx_done = 0;
    send(d);
    for (int k = 0; k < NBITS * BIT_CLKS + 8; k++) begin
      if (k % BIT_CLKS == BIT_CLKS / 2) begin
        b = k / BIT_CLKS;
        if (b == 0) start_ok = (tx === 1'b0);
        else if (b <= 8) rx_byte[b-1] = tx;
        else if (b == NBITS - 1) begin
          stop_ok = (tx === 1'b1);
          rx_done++;
        end
      end
      if (tx_done_tick === 1'b1) tx_done++;
      @(negedge clock);
    end
    checks++;
    if (rx_byte !== d || !start_ok || !stop_ok) begin
      errors++;
      $display("FAIL loopback_byte: got %h start_ok=%b stop_ok=%b required %h", rx_byte, start_ok, stop_ok, d);
    end
    checks++;
    if (rx_done != 1 || tx_done != 1) begin
      errors++;
      $display("FAIL loopback_done: rx_done=%0d tx_done=%0d required 1 and 1", rx_done, tx_done);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef TX_UART_PARITY_EN
    test_parity();
`endif
    test_loopback(8'h00);
    test_loopback(8'hFF);
    test_loopback(8'h5A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1);
  end

endmodule
